// File: rtl/md_pkg.sv
// Shared multiply/divide op encodings and op-classification helpers.
// MD_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate ops to the multiply class.
package md_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;
    localparam logic [3:0] MD_MSUB  = 4'd8;
    localparam logic [3:0] MD_MSUBU = 4'd9;

    // Ops that occupy the unit for MUL_LAT cycles.
    function automatic logic is_mul(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU: is_mul = 1'b1;
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: is_mul = 1'b1;
`endif
            default: is_mul = 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        is_div = (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result of a multiply/divide op given operands and current {hi,lo}.
// MD_MADD_EN enables the accumulate/subtract forms; otherwise they fall through to hilo.
module md_calc
    import md_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [63:0] hilo,
    output logic [63:0] result
);

    logic [63:0] rs_sx;
    logic [63:0] rt_sx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign rs_sx  = {{32{rs[31]}}, rs};
    assign rt_sx  = {{32{rt[31]}}, rt};
    // The low 64 bits of a sign-extended product are the exact signed product.
    assign prod_s = rs_sx * rt_sx;
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    logic        rt_zero;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [31:0] div_s;
    logic [31:0] div_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign rt_zero = (rt == 32'd0);
    assign abs_rs  = rs[31] ? (32'd0 - rs) : rs;
    assign abs_rt  = rt[31] ? (32'd0 - rt) : rt;
    // Divisor forced to 1 on zero so the divider never sees x/0; result is overridden below.
    assign div_s   = rt_zero ? 32'd1 : abs_rt;
    assign div_u   = rt_zero ? 32'd1 : rt;
    assign q_mag   = abs_rs / div_s;
    assign r_mag   = abs_rs % div_s;
    // Magnitude division then sign fix-up also yields 0x80000000 / -1 = 0x80000000, rem 0.
    assign q_s     = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s     = rs[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u     = rs / div_u;
    assign r_u     = rs % div_u;

    always_comb begin
        result = hilo;
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = rt_zero ? {rs, 32'hFFFF_FFFF} : {r_s, q_s};
            MD_DIVU:  result = rt_zero ? {rs, 32'hFFFF_FFFF} : {r_u, q_u};
`ifdef MD_MADD_EN
            MD_MADD:  result = hilo + prod_s;
            MD_MADDU: result = hilo + prod_u;
            MD_MSUB:  result = hilo - prod_s;
            MD_MSUBU: result = hilo - prod_u;
`endif
            default:  result = hilo;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; multi-cycle ops commit after MUL_LAT/DIV_LAT cycles.
// Build option MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU (handled via md_pkg::is_mul and md_calc).
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT + 1) : 1;

    // Handshake: an op is taken when start=1 and busy=0 at a rising edge; the hazard
    // unit guarantees start is never raised while busy=1, so no back-pressure is needed.

    logic [CNT_W-1:0] count;
    logic [63:0]      pending;
    logic [63:0]      calc_result;

    md_calc u_calc (
        .md_op  (md_op),
        .rs     (rs_e),
        .rt     (rt_e),
        .hilo   ({hi, lo}),
        .result (calc_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            busy    <= 1'b0;
            count   <= '0;
            pending <= 64'd0;
        end else if (busy) begin
            if (count == CNT_W'(1)) begin
                hi   <= pending[63:32];
                lo   <= pending[31:0];
                busy <= 1'b0;
            end
            count <= count - CNT_W'(1);
        end else if (start) begin
            if (md_op == MD_MTHI) begin
                hi <= rs_e;
            end else if (md_op == MD_MTLO) begin
                lo <= rs_e;
            end else if (is_mul(md_op)) begin
                pending <= calc_result;
                count   <= CNT_W'(MUL_LAT);
                busy    <= 1'b1;
            end else if (is_div(md_op)) begin
                pending <= calc_result;
                count   <= CNT_W'(DIV_LAT);
                busy    <= 1'b1;
            end
        end
    end

    // A start while busy would be silently dropped; flag it as a hazard-unit bug.
    always_ff @(posedge clk) begin
        if (reset_n && busy) begin
            assert (!start) else $error("md_unit: start asserted while busy");
        end
    end

endmodule
